// File: rtl/an_corrector_n37.sv
// Single-bit error corrector for A=37 AN codes: walks bit positions serially, tracking 2^i = 37*f + w.
// Optional statistics counters are built when AN_CORR_STATS_EN is defined.
module an_corrector_n37 #(
    parameter int A    = 37,
    parameter int CW_W = 18,
    parameter int Q_W  = 13,
    parameter int R_W  = 6,
    parameter int MAXD = 7084
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [12:0]    in_q,
    input  logic [5:0]     in_r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [12:0]    out_data,
    output logic           out_corrected,
    output logic           out_uncorr,
    output logic [4:0]     out_err_pos,
    output logic           out_err_neg,
    output logic [15:0]    cnt_corrected,
    output logic [15:0]    cnt_uncorr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int CAND_W = Q_W + 2;
    localparam logic signed [CAND_W-1:0] MAXD_S = CAND_W'(MAXD);

    logic [1:0]     state_q, state_d;
    logic [Q_W-1:0] q_q, q_d;
    logic [R_W-1:0] r_q, r_d;
    logic [4:0]     i_q, i_d;
    logic [R_W-1:0] w_q, w_d;
    logic [Q_W-1:0] f_q, f_d;

    logic           valid_q, valid_d;
    logic [Q_W-1:0] data_q, data_d;
    logic           corr_q, corr_d;
    logic           uncorr_q, uncorr_d;
    logic [4:0]     pos_q, pos_d;
    logic           neg_q, neg_d;

    logic                     match_pos, match_neg;
    logic [R_W-1:0]           a_minus_w;
    logic [R_W:0]             w2;
    logic signed [CAND_W-1:0] q_ext, f_ext, cand;

    function automatic logic cand_in_range(input logic signed [CAND_W-1:0] v);
        return (v >= 0) && (v <= MAXD_S);
    endfunction

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_corrected = corr_q;
    assign out_uncorr    = uncorr_q;
    assign out_err_pos   = pos_q;
    assign out_err_neg   = neg_q;

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        r_d      = r_q;
        i_d      = i_q;
        w_d      = w_q;
        f_d      = f_q;
        valid_d  = valid_q;
        data_d   = data_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        pos_d    = pos_q;
        neg_d    = neg_q;

        // A received word is either c+2^i (residue w) or c-2^i (residue A-w)
        a_minus_w = R_W'(A) - w_q;
        match_pos = (w_q == r_q);
        match_neg = (a_minus_w == r_q);
        w2        = {w_q, 1'b0};
        q_ext     = $signed({2'b00, q_q});
        f_ext     = $signed({2'b00, f_q});
        cand      = match_neg ? (q_ext + f_ext + CAND_W'(1)) : (q_ext - f_ext);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    q_d = in_q;
                    r_d = in_r;
                    i_d = 5'd0;
                    w_d = R_W'(1);
                    f_d = '0;
                    if (in_r == '0) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        data_d   = in_q;
                        corr_d   = 1'b0;
                        uncorr_d = 1'b0;
                        pos_d    = 5'd0;
                        neg_d    = 1'b0;
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if (match_pos || match_neg) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    if (cand_in_range(cand)) begin
                        data_d   = cand[Q_W-1:0];
                        corr_d   = 1'b1;
                        uncorr_d = 1'b0;
                        pos_d    = i_q;
                        neg_d    = match_neg;
                    end else begin
                        data_d   = q_q;
                        corr_d   = 1'b0;
                        uncorr_d = 1'b1;
                        pos_d    = 5'd0;
                        neg_d    = 1'b0;
                    end
                end else if (i_q == 5'(CW_W - 1)) begin
                    // Residues >= A never match any power of two
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    data_d   = q_q;
                    corr_d   = 1'b0;
                    uncorr_d = 1'b1;
                    pos_d    = 5'd0;
                    neg_d    = 1'b0;
                end else begin
                    i_d = i_q + 5'd1;
                    if (w2 >= (R_W + 1)'(A)) begin
                        w_d = R_W'(w2 - (R_W + 1)'(A));
                        f_d = {f_q[Q_W-2:0], 1'b1};
                    end else begin
                        w_d = w2[R_W-1:0];
                        f_d = {f_q[Q_W-2:0], 1'b0};
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b0;
                    data_d   = '0;
                    corr_d   = 1'b0;
                    uncorr_d = 1'b0;
                    pos_d    = 5'd0;
                    neg_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
            pos_q    <= 5'd0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
        end
    end

    // Search working registers carry data only; the FSM qualifies them
    always_ff @(posedge clk) begin
        q_q <= q_d;
        r_q <= r_d;
        i_q <= i_d;
        w_q <= w_d;
        f_q <= f_d;
    end

`ifdef AN_CORR_STATS_EN
    logic [15:0] cnt_corr_q, cnt_corr_d;
    logic [15:0] cnt_unc_q, cnt_unc_d;
    logic        out_fire;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        out_fire   = valid_q && out_ready;
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        if (out_fire && corr_q) cnt_corr_d = sat_inc(cnt_corr_q);
        if (out_fire && uncorr_q) cnt_unc_d = sat_inc(cnt_unc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_corr_q <= 16'd0;
            cnt_unc_q  <= 16'd0;
        end else begin
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
        end
    end

    assign cnt_corrected = cnt_corr_q;
    assign cnt_uncorr    = cnt_unc_q;
`else
    assign cnt_corrected = 16'd0;
    assign cnt_uncorr    = 16'd0;
`endif

endmodule

// File: tb/tb_an_corrector_n37.sv
// Scoreboard bench for an_corrector_n37: driver pushes hand-computed expectations, monitor checks outputs.
module tb_an_corrector_n37;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_q = '0;
    logic [5:0]  in_r = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] out_data;
    logic        out_corrected;
    logic        out_uncorr;
    logic [4:0]  out_err_pos;
    logic        out_err_neg;
    logic [15:0] cnt_corrected;
    logic [15:0] cnt_uncorr;

    an_corrector_n37 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_r(in_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corrected(out_corrected), .out_uncorr(out_uncorr),
        .out_err_pos(out_err_pos), .out_err_neg(out_err_neg),
        .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] data;
        logic        corr;
        logic        unc;
        logic [4:0]  pos;
        logic        neg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cc = 0;
    int   exp_cu = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: snapshots the first cycle of each output, checks stability while held
    bit          seen = 1'b0;
    bit          stable_ok;
    int          lat_act;
    logic [20:0] snap;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                stable_ok = 1'b1;
                snap      = {out_data, out_corrected, out_uncorr, out_err_pos, out_err_neg};
                lat_act   = (exp_q.size() > 0) ? (cyc - exp_q[0].acc + 1) : -1;
            end else if (snap !== {out_data, out_corrected, out_uncorr, out_err_pos, out_err_neg}) begin
                stable_ok = 1'b0;
            end
            if (in_ready) stable_ok = 1'b0;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data", 32'(out_data), 32'(e.data));
                    chk("corrected", 32'(out_corrected), 32'(e.corr));
                    chk("uncorr", 32'(out_uncorr), 32'(e.unc));
                    if (e.corr) begin
                        chk("err_pos", 32'(out_err_pos), 32'(e.pos));
                        chk("err_neg", 32'(out_err_neg), 32'(e.neg));
                    end
                    chk("latency", 32'(lat_act), 32'(e.lat));
                    chk("stable_while_held", 32'(stable_ok), 32'd1);
                    if (e.corr) exp_cc++;
                    if (e.unc) exp_cu++;
                end
                seen = 1'b0;
            end
        end
    end

    task automatic check_counters();
`ifdef AN_CORR_STATS_EN
        chk("cnt_corrected", 32'(cnt_corrected), 32'(exp_cc));
        chk("cnt_uncorr", 32'(cnt_uncorr), 32'(exp_cu));
`else
        chk("cnt_corrected", 32'(cnt_corrected), 32'd0);
        chk("cnt_uncorr", 32'(cnt_uncorr), 32'd0);
`endif
    endtask

    task automatic accept(input logic [12:0] q, input logic [5:0] r, output int acc);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_q     = q;
        in_r     = r;
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [12:0] q, input logic [5:0] r,
                        input logic [12:0] data, input logic corr, input logic unc,
                        input logic [4:0] pos, input logic neg, input int lat, input int hold);
        exp_t e;
        int   acc;
        int   t;
        if (hold > 0) out_ready = 1'b0;
        accept(q, r, acc);
        e.data = data; e.corr = corr; e.unc = unc; e.pos = pos; e.neg = neg;
        e.lat = lat; e.acc = acc;
        exp_q.push_back(e);
        if (hold > 0) begin
            t = 0;
            while (!out_valid && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("output_timeout", 32'd0, 32'd1);
            exp_q.delete();
            seen = 1'b0;
        end
        check_counters();
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flags", {29'd0, out_corrected, out_uncorr, out_err_neg}, 32'd0);
        check_counters();

        //     q     r     data  corr unc pos  neg lat hold
        send(100,  0,   100,  0,   0,  0,  0,  1,  0);   // clean
        send(100,  8,   100,  1,   0,  3,  0,  5,  0);   // +2^3
        send(99,   33,  100,  1,   0,  2,  1,  4,  0);   // -2^2
        send(1871, 9,   100,  1,   0,  16, 0,  18, 0);   // +2^16, f=1771
        send(7084, 35,  7084, 0,   1,  0,  0,  3,  0);   // candidate 7085 > MAXD
        send(5,    40,  5,    0,   1,  0,  0,  19, 0);   // residue >= A, exhausted
        send(7083, 35,  7084, 1,   0,  1,  1,  3,  0);   // lands exactly on MAXD
        send(0,    27,  0,    0,   1,  0,  0,  8,  0);   // 0 - 1 underflows
        send(50,   10,  52,   1,   0,  6,  1,  8,  0);   // -2^6, f=1
        send(100,  8,   100,  1,   0,  3,  0,  5,  10);  // held 10 cycles

        // Reset mid-search: the word is dropped and nothing is presented
        accept(13'd5, 6'd40, acc);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        exp_cc = 0;
        exp_cu = 0;
        repeat (25) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        check_counters();

        send(99, 33, 100, 1, 0, 2, 1, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
